am_indx_ctrl: RTL and testbench

Sequencer for the AM modulation-index calculator. Accepts peak-to-peak envelope measurements, rejects no-signal captures, and drives the calculator through one calculation per measurement. Each calculation is bounded by a pls-tick timeout. The block averages 2^AVG_LOG2 results and publishes the averaged index with a one-cycle valid strobe. It sits between the envelope peak detector and the index calculator (pp_t2b/pp_b2t/up_dni in, indx_dn/indx_cal out).

---
 rtl/am_indx_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_am_indx_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/am_indx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : am_indx_ctrl
// Purpose  : Sequencer for the AM modulation-index calculator. Latches one
//            peak-to-peak measurement and rejects captures whose summed
//            swing is below PP_MIN. For each accepted capture it runs one
//            timeout-bounded calculation. It averages 2^AVG_LOG2 results and
//            publishes the average with a one-cycle valid strobe.
// Ports    : clk, rst (async, active-low), pls (calc tick), en (enable/abort)
//            meas_vld/pp_hi/pp_lo     - measurement from the peak detector
//            cal_dn/cal_indx          - result from the index calculator
//            cal_up_dni/cal_pls       - run request and gated tick to calculator
//            cal_pp_t2b/cal_pp_b2t    - latched measurement for the calculator
//            indx_out/indx_vld        - averaged index and its update strobe
//            busy, low_sig, tmo_err, meas_drop - status and event strobes
// Revision : 1.0 - initial release
// ============================================================================
module am_indx_ctrl #(
  parameter int AVG_LOG2 = 2,
  parameter int TMO_PLS  = 200,
  parameter int PP_MIN   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pls,
  input  logic        en,
  input  logic        meas_vld,
  input  logic [11:0] pp_hi,
  input  logic [11:0] pp_lo,
  input  logic        cal_dn,
  input  logic [7:0]  cal_indx,
  output logic        cal_up_dni,
  output logic        cal_pls,
  output logic [11:0] cal_pp_t2b,
  output logic [11:0] cal_pp_b2t,
  output logic [7:0]  indx_out,
  output logic        indx_vld,
  output logic        busy,
  output logic        low_sig,
  output logic        tmo_err,
  output logic        meas_drop
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0] AVG_N    = CNT_W'(1 << AVG_LOG2);
  localparam logic [12:0]      PP_MIN_C = 13'(PP_MIN);
  localparam logic [7:0]       TMO_LAST = 8'(TMO_PLS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_CALC  = 2'd2;
  localparam logic [1:0] S_REL   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [11:0]      pp_hi_q, pp_hi_d;
  logic [11:0]      pp_lo_q, pp_lo_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [7:0]       out_q, out_d;
  logic             vld_q, vld_d;
  logic             low_q, low_d;
  logic             tmo_err_q, tmo_err_d;
  logic             drop_q, drop_d;

  logic [12:0]      w_sum;
  logic [ACC_W-1:0] w_acc_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tmo_hit;

  // 13-bit sum so two full-scale 12-bit swings never wrap.
  assign w_sum     = {1'b0, pp_hi_q} + {1'b0, pp_lo_q};
  // The accumulator holds at most 2^AVG_LOG2 - 1 results here, so adding one
  // more 8-bit value cannot overflow ACC_W bits.
  assign w_acc_sum = acc_q + ACC_W'(cal_indx);
  assign w_cnt_inc = cnt_q + CNT_W'(1);
  // This tick would be the TMO_PLS-th one of the current calculation.
  assign w_tmo_hit = pls & (tmo_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    pp_hi_d   = pp_hi_q;
    pp_lo_d   = pp_lo_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    out_d     = out_q;
    vld_d     = 1'b0;
    low_d     = 1'b0;
    tmo_err_d = 1'b0;
    drop_d    = meas_vld & (state_q != S_IDLE);

    if (!en) begin
      // Abort: partial averages are discarded, the published index is kept.
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (meas_vld) begin
            pp_hi_d = pp_hi;
            pp_lo_d = pp_lo;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_sum < PP_MIN_C) begin
            low_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            tmo_d   = '0;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          if (pls) begin
            tmo_d = tmo_q + 8'd1;
          end
          // A done strobe takes priority over a coincident timeout.
          if (cal_dn) begin
            state_d = S_REL;
            // The average is resolved here so that indx_vld is registered
            // into the REL cycle.
            if (w_cnt_inc == AVG_N) begin
              out_d = w_acc_sum[AVG_LOG2 +: 8];
              vld_d = 1'b1;
              acc_d = '0;
              cnt_d = '0;
            end else begin
              acc_d = w_acc_sum;
              cnt_d = w_cnt_inc;
            end
          end else if (w_tmo_hit) begin
            tmo_err_d = 1'b1;
            state_d   = S_REL;
          end
        end
        S_REL: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pp_hi_q   <= '0;
      pp_lo_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      out_q     <= '0;
      vld_q     <= 1'b0;
      low_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pp_hi_q   <= pp_hi_d;
      pp_lo_q   <= pp_lo_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      out_q     <= out_d;
      vld_q     <= vld_d;
      low_q     <= low_d;
      tmo_err_q <= tmo_err_d;
      drop_q    <= drop_d;
    end
  end

  assign cal_up_dni = (state_q == S_CALC);
  assign cal_pls    = pls & cal_up_dni;
  assign cal_pp_t2b = pp_hi_q;
  assign cal_pp_b2t = pp_lo_q;
  assign indx_out   = out_q;
  assign indx_vld   = vld_q;
  assign busy       = (state_q != S_IDLE);
  assign low_sig    = low_q;
  assign tmo_err    = tmo_err_q;
  assign meas_drop  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_am_indx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_am_indx_ctrl
// Purpose  : Self-checking bench for am_indx_ctrl (default parameters).
//            Table vectors, randomized transactions against a result-queue
//            model, and hand sequences for drop, abort and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am_indx_ctrl;

  localparam int C_TMO    = 200;
  localparam int C_PP_MIN = 16;
  localparam int C_AVG_N  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pls = 1'b0;
  logic        en = 1'b0;
  logic        meas_vld = 1'b0;
  logic [11:0] pp_hi = '0;
  logic [11:0] pp_lo = '0;
  logic        cal_dn = 1'b0;
  logic [7:0]  cal_indx = '0;
  logic        cal_up_dni;
  logic        cal_pls;
  logic [11:0] cal_pp_t2b;
  logic [11:0] cal_pp_b2t;
  logic [7:0]  indx_out;
  logic        indx_vld;
  logic        busy;
  logic        low_sig;
  logic        tmo_err;
  logic        meas_drop;

  int checks   = 0;
  int failures = 0;

  am_indx_ctrl #(.AVG_LOG2(2), .TMO_PLS(C_TMO), .PP_MIN(C_PP_MIN)) dut (
    .clk(clk), .rst(rst), .pls(pls), .en(en), .meas_vld(meas_vld),
    .pp_hi(pp_hi), .pp_lo(pp_lo), .cal_dn(cal_dn), .cal_indx(cal_indx),
    .cal_up_dni(cal_up_dni), .cal_pls(cal_pls), .cal_pp_t2b(cal_pp_t2b),
    .cal_pp_b2t(cal_pp_b2t), .indx_out(indx_out), .indx_vld(indx_vld),
    .busy(busy), .low_sig(low_sig), .tmo_err(tmo_err), .meas_drop(meas_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] hi;
    logic [11:0] lo;
    int          dn;    // pls tick carrying cal_dn; 0 = never
    logic [7:0]  v;
    bit          low;
    bit          tmo;
    bit          vld;
    logic [7:0]  out;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] q[$];     // accepted results awaiting an average

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // One measurement through the sequencer. Starts and ends in IDLE.
  task automatic run_txn(input logic [11:0] hi, input logic [11:0] lo, input int dn_tick,
                         input logic [7:0] v, output bit o_low, output bit o_tmo,
                         output bit o_vld, output logic [7:0] o_out);
    int ticks;
    int cyc;
    meas_vld = 1'b1; pp_hi = hi; pp_lo = lo;
    step;
    meas_vld = 1'b0; pp_hi = 12'($urandom); pp_lo = 12'($urandom);
    chk("check_busy", 32'(busy), 32'd1);
    chk("check_up_low", 32'(cal_up_dni), 32'd0);
    chk("strobes_clear", 32'({low_sig, tmo_err, indx_vld}), 32'd0);
    step;
    o_low = low_sig; o_tmo = tmo_err; o_vld = indx_vld; o_out = indx_out;
    if (busy) begin
      chk("calc_up", 32'(cal_up_dni), 32'd1);
      chk("pp_t2b_latched", 32'(cal_pp_t2b), 32'(hi));
      chk("pp_b2t_latched", 32'(cal_pp_b2t), 32'(lo));
      ticks = 0;
      cyc   = 0;
      while (cal_up_dni && cyc < 1000) begin
        pls = 1'b1;
        ticks++;
        if (ticks == dn_tick) begin
          cal_dn = 1'b1; cal_indx = v;
        end
        #1;
        chk("cal_pls", 32'(cal_pls), 32'd1);
        step;
        pls = 1'b0; cal_dn = 1'b0; cal_indx = 8'($urandom);
        cyc++;
      end
      chk("calc_exit", 32'(cal_up_dni), 32'd0);
      chk("rel_busy", 32'(busy), 32'd1);
      o_low = low_sig; o_tmo = tmo_err; o_vld = indx_vld; o_out = indx_out;
      if (o_tmo) chk("tmo_tick_count", 32'(ticks), 32'(C_TMO));
      step;
      chk("idle_after_rel", 32'(busy), 32'd0);
      chk("rel_strobes_1cyc", 32'({tmo_err, indx_vld}), 32'd0);
    end
  endtask

  task automatic cmp_txn(input string tag, input bit el, input bit et, input bit ev,
                         input logic [7:0] eo, input bit gl, input bit gt, input bit gv,
                         input logic [7:0] go);
    chk({tag, "_low_sig"}, 32'(gl), 32'(el));
    chk({tag, "_tmo_err"}, 32'(gt), 32'(et));
    chk({tag, "_indx_vld"}, 32'(gv), 32'(ev));
    if (ev) chk({tag, "_indx_out"}, 32'(go), 32'(eo));
  endtask

  initial begin
    bit         gl, gt, gv;
    logic [7:0] go;
    bit         el, et, ev;
    logic [7:0] eo;
    int         s;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({cal_up_dni, cal_pls, busy, low_sig, tmo_err, meas_drop, indx_vld}), 32'd0);
    chk("rst_indx_out", 32'(indx_out), 32'd0);
    chk("rst_pp", 32'({cal_pp_t2b, cal_pp_b2t}), 32'd0);
    rst = 1'b1; en = 1'b1;
    step;
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Table vectors from a clean accumulator
    vecs[0]  = '{12'd5,    12'd10,   3,   8'd0,   1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{12'd10,   12'd5,    3,   8'd0,   1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{12'd100,  12'd200,  3,   8'd40,  1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{12'd8,    12'd8,    1,   8'd41,  1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{12'd300,  12'd300,  0,   8'd99,  1'b0, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{12'd4095, 12'd4095, 5,   8'd42,  1'b0, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{12'd50,   12'd60,   200, 8'd44,  1'b0, 1'b0, 1'b1, 8'd41};
    vecs[7]  = '{12'd0,    12'd0,    1,   8'd0,   1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{12'd900,  12'd1,    2,   8'd255, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[9]  = '{12'd17,   12'd0,    7,   8'd255, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{12'd0,    12'd16,   201, 8'd9,   1'b0, 1'b1, 1'b0, 8'd0};
    vecs[11] = '{12'd2048, 12'd2048, 1,   8'd255, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[12] = '{12'd33,   12'd44,   199, 8'd253, 1'b0, 1'b0, 1'b1, 8'd254};
    for (int k = 0; k < 13; k++) begin
      run_txn(vecs[k].hi, vecs[k].lo, vecs[k].dn, vecs[k].v, gl, gt, gv, go);
      cmp_txn($sformatf("vec%0d", k), vecs[k].low, vecs[k].tmo, vecs[k].vld, vecs[k].out,
              gl, gt, gv, go);
    end

    // Randomized transactions against a result-queue model
    q.delete();
    for (int k = 0; k < 40; k++) begin
      logic [11:0] hi, lo;
      int          dn;
      logic [7:0]  v;
      if ($urandom_range(0, 3) == 0) begin
        hi = 12'($urandom_range(0, 12)); lo = 12'($urandom_range(0, 12));
      end else begin
        hi = 12'($urandom_range(0, 4095)); lo = 12'($urandom_range(0, 4095));
      end
      dn = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 220));
      v  = 8'($urandom_range(0, 255));
      el = 1'b0; et = 1'b0; ev = 1'b0; eo = 8'd0;
      if (int'(hi) + int'(lo) < C_PP_MIN) begin
        el = 1'b1;
      end else if (dn == 0 || dn > C_TMO) begin
        et = 1'b1;
      end else begin
        q.push_back(v);
        if (q.size() == C_AVG_N) begin
          s = 0;
          foreach (q[j]) s += int'(q[j]);
          ev = 1'b1; eo = 8'(s / C_AVG_N);
          q.delete();
        end
      end
      run_txn(hi, lo, dn, v, gl, gt, gv, go);
      cmp_txn($sformatf("rnd%0d", k), el, et, ev, eo, gl, gt, gv, go);
    end

    // meas_vld during CALC, then abort with en low mid-calculation
    meas_vld = 1'b1; pp_hi = 12'h123; pp_lo = 12'h456;
    step;
    meas_vld = 1'b0;
    step;
    chk("drop_in_calc", 32'(cal_up_dni), 32'd1);
    meas_vld = 1'b1; pp_hi = 12'hABC; pp_lo = 12'hDEF;
    step;
    meas_vld = 1'b0;
    chk("meas_drop_pulse", 32'(meas_drop), 32'd1);
    chk("drop_t2b_kept", 32'(cal_pp_t2b), 32'h123);
    chk("drop_b2t_kept", 32'(cal_pp_b2t), 32'h456);
    chk("drop_still_calc", 32'(cal_up_dni), 32'd1);
    step;
    chk("meas_drop_1cyc", 32'(meas_drop), 32'd0);
    en = 1'b0;
    step;
    en = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_up", 32'(cal_up_dni), 32'd0);
    chk("abort_no_vld", 32'(indx_vld), 32'd0);

    // Partial average discarded by an en drop
    for (int k = 0; k < 2; k++) begin
      run_txn(12'd500, 12'd500, 1, 8'd77, gl, gt, gv, go);
      cmp_txn($sformatf("pre_abort%0d", k), 1'b0, 1'b0, 1'b0, 8'd0, gl, gt, gv, go);
    end
    en = 1'b0;
    step;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_txn(12'd500, 12'd500, 2, 8'd100, gl, gt, gv, go);
      cmp_txn($sformatf("post_abort%0d", k), 1'b0, 1'b0, (k == 3), 8'd100, gl, gt, gv, go);
    end

    // Asynchronous reset while calculating
    meas_vld = 1'b1; pp_hi = 12'h3C3; pp_lo = 12'h0F0;
    step;
    meas_vld = 1'b0;
    step;
    pls = 1'b1;
    #2;
    chk("pre_arst_calc", 32'(cal_pls), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_ctrl", 32'({cal_up_dni, cal_pls, busy, low_sig, tmo_err, meas_drop, indx_vld}), 32'd0);
    chk("arst_indx_out", 32'(indx_out), 32'd0);
    chk("arst_pp", 32'({cal_pp_t2b, cal_pp_b2t}), 32'd0);
    pls = 1'b0;
    step;
    rst = 1'b1;
    step;
    chk("arst_release_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
